// File: rtl/cond_unit_pipe.sv
// Conditional-execution unit: per-context NZCV flag registers plus a short pipe tracking
// in-flight flag updates, stalling dependent instructions or forwarding the arriving flags.
module cond_unit_pipe #(
  parameter int unsigned NCTX     = 2,
  parameter int unsigned FLAG_LAT = 1,
  parameter int unsigned FWD      = 1,
  localparam int unsigned CW      = (NCTX > 1) ? $clog2(NCTX) : 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          Valid,
  input  logic [CW-1:0] Ctx,
  input  logic          PCS,
  input  logic          RegW,
  input  logic          MemW,
  input  logic          NoWrite,
  input  logic [1:0]    FlagW,
  input  logic [3:0]    Cond,
  input  logic [3:0]    ALUFlags,
  input  logic          Flush,
  output logic          PCSrc,
  output logic          RegWrite,
  output logic          MemWrite,
  output logic          CondEx,
  output logic          Stall,
  output logic [3:0]    Flags
);

  localparam int unsigned Oldest = FLAG_LAT - 1;

  typedef struct packed {
    logic          valid;
    logic [CW-1:0] ctx;
    logic [1:0]    flagw;
  } slot_t;

  // Bit 1 = NZ group, bit 0 = CV group.
  function automatic logic [1:0] needed_groups(input logic [3:0] cond);
    logic [1:0] groups;
    unique case (cond)
      4'b0000, 4'b0001, 4'b0100, 4'b0101: groups = 2'b10;
      4'b0010, 4'b0011, 4'b0110, 4'b0111: groups = 2'b01;
      4'b1110, 4'b1111:                   groups = 2'b00;
      default:                            groups = 2'b11;
    endcase
    return groups;
  endfunction

  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, res;
    {n, z, c, v} = nzcv;
    unique case (cond)
      4'b0000: res = z;
      4'b0001: res = !z;
      4'b0010: res = c;
      4'b0011: res = !c;
      4'b0100: res = n;
      4'b0101: res = !n;
      4'b0110: res = v;
      4'b0111: res = !v;
      4'b1000: res = c && !z;
      4'b1001: res = !c || z;
      4'b1010: res = (n == v);
      4'b1011: res = (n != v);
      4'b1100: res = !z && (n == v);
      4'b1101: res = z || (n != v);
      default: res = 1'b1;
    endcase
    return res;
  endfunction

  slot_t         slot_q [FLAG_LAT];
  logic [3:0]    flags_q [NCTX];

  slot_t         oldest;
  slot_t         push_slot;
  logic [CW-1:0] ctx_eff;
  logic [3:0]    committed;
  logic [3:0]    effective;
  logic [1:0]    need;
  logic          fwd_hit;
  logic          hazard;
  logic          cond_ok;
  logic          accept;

  // Out-of-range contexts alias onto context 0.
  always_comb begin
    ctx_eff = Ctx;
    if (32'(Ctx) >= NCTX) ctx_eff = '0;
  end

  assign oldest    = slot_q[Oldest];
  assign committed = flags_q[ctx_eff];

  // The oldest slot's flags arrive on ALUFlags this cycle; bypass them per group.
  always_comb begin
    fwd_hit   = (FWD != 0) && oldest.valid && (oldest.ctx == ctx_eff) && !Flush;
    effective = committed;
    if (fwd_hit) begin
      if (oldest.flagw[1]) effective[3:2] = ALUFlags[3:2];
      if (oldest.flagw[0]) effective[1:0] = ALUFlags[1:0];
    end
  end

  always_comb begin
    need   = needed_groups(Cond);
    hazard = 1'b0;
    for (int i = 0; i < int'(FLAG_LAT); i++) begin
      if (slot_q[i].valid && (slot_q[i].ctx == ctx_eff) && ((slot_q[i].flagw & need) != 2'b00)
          && !((FWD != 0) && (i == int'(Oldest)))) begin
        hazard = 1'b1;
      end
    end
    hazard = hazard && Valid && !RESET;
  end

  assign cond_ok  = cond_holds(Cond, effective);
  assign accept   = Valid && !hazard && !RESET;

  assign Stall    = hazard;
  assign CondEx   = cond_ok && !RESET;
  assign PCSrc    = accept && PCS && cond_ok;
  assign RegWrite = accept && RegW && cond_ok && !NoWrite;
  assign MemWrite = accept && MemW && cond_ok;
  assign Flags    = committed;

  // Only instructions that actually execute and write flags reserve a slot.
  always_comb begin
    push_slot.valid = accept && cond_ok && (FlagW != 2'b00);
    push_slot.ctx   = ctx_eff;
    push_slot.flagw = FlagW;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int c = 0; c < int'(NCTX); c++) flags_q[c] <= 4'h0;
      for (int i = 0; i < int'(FLAG_LAT); i++) slot_q[i] <= '0;
    end else begin
      if (oldest.valid && !Flush) begin
        if (oldest.flagw[1]) flags_q[oldest.ctx][3:2] <= ALUFlags[3:2];
        if (oldest.flagw[0]) flags_q[oldest.ctx][1:0] <= ALUFlags[1:0];
      end
      for (int i = 1; i < int'(FLAG_LAT); i++) slot_q[i] <= Flush ? '0 : slot_q[i-1];
      slot_q[0] <= push_slot;
    end
  end

endmodule

// File: tb/tb_cond_unit_pipe.sv
// Bench for cond_unit_pipe: three configurations (lat1/fwd, lat2/no-fwd/3 ctx, lat2/fwd)
// checked by directed scenarios and a randomized run against a pending-write queue model.
module tb_cond_unit_pipe;

  logic       clk;
  logic       rst;
  logic       valid_i [3];
  logic [1:0] ctx_i   [3];
  logic       pcs_i   [3];
  logic       regw_i  [3];
  logic       memw_i  [3];
  logic       nowr_i  [3];
  logic [1:0] flagw_i [3];
  logic [3:0] cond_i  [3];
  logic [3:0] alu_i   [3];
  logic       flush_i [3];

  wire        pcsrc_o  [3];
  wire        regw_o   [3];
  wire        memw_o   [3];
  wire        condex_o [3];
  wire        stall_o  [3];
  wire  [3:0] flags_o  [3];

  int n_pass  = 0;
  int n_total = 0;

  cond_unit_pipe #(.NCTX(2), .FLAG_LAT(1), .FWD(1)) dut_a (
    .CLK(clk), .RESET(rst), .Valid(valid_i[0]), .Ctx(ctx_i[0][0]), .PCS(pcs_i[0]),
    .RegW(regw_i[0]), .MemW(memw_i[0]), .NoWrite(nowr_i[0]), .FlagW(flagw_i[0]),
    .Cond(cond_i[0]), .ALUFlags(alu_i[0]), .Flush(flush_i[0]), .PCSrc(pcsrc_o[0]),
    .RegWrite(regw_o[0]), .MemWrite(memw_o[0]), .CondEx(condex_o[0]), .Stall(stall_o[0]),
    .Flags(flags_o[0])
  );

  cond_unit_pipe #(.NCTX(3), .FLAG_LAT(2), .FWD(0)) dut_b (
    .CLK(clk), .RESET(rst), .Valid(valid_i[1]), .Ctx(ctx_i[1]), .PCS(pcs_i[1]),
    .RegW(regw_i[1]), .MemW(memw_i[1]), .NoWrite(nowr_i[1]), .FlagW(flagw_i[1]),
    .Cond(cond_i[1]), .ALUFlags(alu_i[1]), .Flush(flush_i[1]), .PCSrc(pcsrc_o[1]),
    .RegWrite(regw_o[1]), .MemWrite(memw_o[1]), .CondEx(condex_o[1]), .Stall(stall_o[1]),
    .Flags(flags_o[1])
  );

  cond_unit_pipe #(.NCTX(2), .FLAG_LAT(2), .FWD(1)) dut_c (
    .CLK(clk), .RESET(rst), .Valid(valid_i[2]), .Ctx(ctx_i[2][0]), .PCS(pcs_i[2]),
    .RegW(regw_i[2]), .MemW(memw_i[2]), .NoWrite(nowr_i[2]), .FlagW(flagw_i[2]),
    .Cond(cond_i[2]), .ALUFlags(alu_i[2]), .Flush(flush_i[2]), .PCSrc(pcsrc_o[2]),
    .RegWrite(regw_o[2]), .MemWrite(memw_o[2]), .CondEx(condex_o[2]), .Stall(stall_o[2]),
    .Flags(flags_o[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Pending flag writes are kept as {instance, context, groups, cycle their ALUFlags arrive}.
  typedef struct {
    int         d;
    int         ctx;
    logic [1:0] fw;
    int         due;
  } pend_t;

  int         p_nctx [3] = '{2, 3, 2};
  int         p_lat  [3] = '{1, 2, 2};
  int         p_fwd  [3] = '{1, 0, 1};
  pend_t      pq [$];
  logic [3:0] mflags [3][8];
  int         now = 0;
  logic       e_stall [3], e_condex [3], e_pcsrc [3], e_regw [3], e_memw [3];
  logic [3:0] e_flags [3];

  function automatic logic [1:0] needs(input logic [3:0] c);
    case (c)
      4'h0, 4'h1, 4'h4, 4'h5: return 2'b10;
      4'h2, 4'h3, 4'h6, 4'h7: return 2'b01;
      4'he, 4'hf:             return 2'b00;
      default:                return 2'b11;
    endcase
  endfunction

  function automatic logic holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cf && !z;
      4'h9: return !cf || z;
      4'ha: return n == v;
      4'hb: return n != v;
      4'hc: return !z && (n == v);
      4'hd: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic int eff_ctx(input int d);
    int raw;
    raw = (d == 1) ? int'(ctx_i[1]) : int'(ctx_i[d][0]);
    return (raw >= p_nctx[d]) ? 0 : raw;
  endfunction

  task automatic model_eval();
    for (int d = 0; d < 3; d++) begin
      int         c;
      logic [3:0] eff;
      logic       haz;
      logic       ok;
      logic       acc;
      c   = eff_ctx(d);
      eff = mflags[d][c];
      haz = 1'b0;
      foreach (pq[k]) begin
        if (pq[k].d == d && pq[k].ctx == c) begin
          if (pq[k].due == now && p_fwd[d] != 0) begin
            if (!flush_i[d]) begin
              if (pq[k].fw[1]) eff[3:2] = alu_i[d][3:2];
              if (pq[k].fw[0]) eff[1:0] = alu_i[d][1:0];
            end
          end else if ((pq[k].fw & needs(cond_i[d])) != 2'b00) begin
            haz = 1'b1;
          end
        end
      end
      haz = haz && valid_i[d];
      ok  = holds(cond_i[d], eff);
      acc = valid_i[d] && !haz;
      if (rst) begin
        e_stall[d] = 0; e_condex[d] = 0; e_pcsrc[d] = 0; e_regw[d] = 0; e_memw[d] = 0;
      end else begin
        e_stall[d]  = haz;
        e_condex[d] = ok;
        e_pcsrc[d]  = acc && pcs_i[d] && ok;
        e_regw[d]   = acc && regw_i[d] && ok && !nowr_i[d];
        e_memw[d]   = acc && memw_i[d] && ok;
      end
      e_flags[d] = mflags[d][c];
    end
  endtask

  task automatic model_commit();
    pend_t keep [$];
    foreach (pq[k]) begin
      if (rst) begin
        // dropped
      end else if (pq[k].due == now) begin
        if (!flush_i[pq[k].d]) begin
          if (pq[k].fw[1]) mflags[pq[k].d][pq[k].ctx][3:2] = alu_i[pq[k].d][3:2];
          if (pq[k].fw[0]) mflags[pq[k].d][pq[k].ctx][1:0] = alu_i[pq[k].d][1:0];
        end
      end else if (!flush_i[pq[k].d]) begin
        keep.push_back(pq[k]);
      end
    end
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        for (int c = 0; c < 8; c++) mflags[d][c] = 4'h0;
      end else if (valid_i[d] && !e_stall[d] && e_condex[d] && flagw_i[d] != 2'b00) begin
        pend_t p;
        p.d = d; p.ctx = eff_ctx(d); p.fw = flagw_i[d]; p.due = now + p_lat[d];
        keep.push_back(p);
      end
    end
    pq = keep;
    now++;
  endtask

  task automatic clk_edge();
    model_eval();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle_all();
    for (int d = 0; d < 3; d++) begin
      valid_i[d] = 0; ctx_i[d] = 0; pcs_i[d] = 0; regw_i[d] = 0; memw_i[d] = 0;
      nowr_i[d] = 0; flagw_i[d] = 0; cond_i[d] = 4'he; alu_i[d] = 0; flush_i[d] = 0;
    end
  endtask

  task automatic issue(input int d, input int ctx, input logic [3:0] cond, input logic [1:0] fw);
    valid_i[d] = 1; ctx_i[d] = 2'(ctx); cond_i[d] = cond; flagw_i[d] = fw;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1;
    for (int d = 0; d < 3; d++) begin
      issue(d, 0, 4'he, 2'b11); pcs_i[d] = 1; regw_i[d] = 1; memw_i[d] = 1;
    end
    clk_edge();
    clk_edge();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_total++; if (pcsrc_o[d] !== 1'b0) $display("FAIL reset_pcsrc d=%0d: got %b want 0", d, pcsrc_o[d]); else n_pass++;
      n_total++; if (regw_o[d] !== 1'b0) $display("FAIL reset_regwrite d=%0d: got %b want 0", d, regw_o[d]); else n_pass++;
      n_total++; if (memw_o[d] !== 1'b0) $display("FAIL reset_memwrite d=%0d: got %b want 0", d, memw_o[d]); else n_pass++;
      n_total++; if (condex_o[d] !== 1'b0) $display("FAIL reset_condex d=%0d: got %b want 0", d, condex_o[d]); else n_pass++;
      n_total++; if (stall_o[d] !== 1'b0) $display("FAIL reset_stall d=%0d: got %b want 0", d, stall_o[d]); else n_pass++;
      n_total++; if (flags_o[d] !== 4'h0) $display("FAIL reset_flags d=%0d: got %h want 0", d, flags_o[d]); else n_pass++;
    end
    clk_edge();
    rst = 0;
    idle_all();
    clk_edge();
  endtask

  task automatic test_cond_basic();
    issue(0, 0, 4'h0, 2'b00); pcs_i[0] = 1;
    @(negedge clk);
    n_total++; if (condex_o[0] !== 1'b0) $display("FAIL basic_eq_condex: got %b want 0", condex_o[0]); else n_pass++;
    n_total++; if (pcsrc_o[0] !== 1'b0) $display("FAIL basic_eq_pcsrc: got %b want 0", pcsrc_o[0]); else n_pass++;
    clk_edge();
    cond_i[0] = 4'he; regw_i[0] = 1; memw_i[0] = 1;
    @(negedge clk);
    n_total++; if (pcsrc_o[0] !== 1'b1) $display("FAIL basic_al_pcsrc: got %b want 1", pcsrc_o[0]); else n_pass++;
    n_total++; if (regw_o[0] !== 1'b1) $display("FAIL basic_al_regwrite: got %b want 1", regw_o[0]); else n_pass++;
    n_total++; if (memw_o[0] !== 1'b1) $display("FAIL basic_al_memwrite: got %b want 1", memw_o[0]); else n_pass++;
    clk_edge();
    nowr_i[0] = 1;
    @(negedge clk);
    n_total++; if (regw_o[0] !== 1'b0) $display("FAIL basic_nowrite: got %b want 0", regw_o[0]); else n_pass++;
    clk_edge();
    valid_i[0] = 0; cond_i[0] = 4'h1; nowr_i[0] = 0;
    @(negedge clk);
    n_total++; if (condex_o[0] !== 1'b1) $display("FAIL basic_ne_condex: got %b want 1", condex_o[0]); else n_pass++;
    n_total++; if (pcsrc_o[0] !== 1'b0) $display("FAIL basic_invalid_pcsrc: got %b want 0", pcsrc_o[0]); else n_pass++;
    clk_edge();
    idle_all();
    clk_edge();
  endtask

  task automatic test_flush();
    issue(0, 0, 4'he, 2'b11);
    clk_edge();
    flush_i[0] = 1; alu_i[0] = 4'hf; issue(0, 0, 4'he, 2'b11);
    @(negedge clk);
    n_total++; if (stall_o[0] !== 1'b0) $display("FAIL flush_push_stall: got %b want 0", stall_o[0]); else n_pass++;
    clk_edge();
    idle_all(); alu_i[0] = 4'h8;
    @(negedge clk);
    n_total++; if (flags_o[0] !== 4'h0) $display("FAIL flush_no_commit: got %h want 0", flags_o[0]); else n_pass++;
    clk_edge();
    idle_all();
    @(negedge clk);
    n_total++; if (flags_o[0] !== 4'h8) $display("FAIL flush_pushed_commit: got %h want 8", flags_o[0]); else n_pass++;
    clk_edge();
  endtask

  task automatic test_no_reserve();
    issue(0, 0, 4'h0, 2'b11);
    @(negedge clk);
    n_total++; if (condex_o[0] !== 1'b0) $display("FAIL noreserve_condex: got %b want 0", condex_o[0]); else n_pass++;
    clk_edge();
    alu_i[0] = 4'hf; issue(0, 0, 4'h0, 2'b00);
    @(negedge clk);
    n_total++; if (stall_o[0] !== 1'b0) $display("FAIL noreserve_stall: got %b want 0", stall_o[0]); else n_pass++;
    clk_edge();
    idle_all();
    @(negedge clk);
    n_total++; if (flags_o[0] !== 4'h8) $display("FAIL noreserve_flags: got %h want 8", flags_o[0]); else n_pass++;
    clk_edge();
  endtask

  task automatic test_forward();
    issue(0, 0, 4'he, 2'b11);
    clk_edge();
    alu_i[0] = 4'h4; issue(0, 0, 4'h0, 2'b00); pcs_i[0] = 1;
    @(negedge clk);
    n_total++; if (stall_o[0] !== 1'b0) $display("FAIL fwd_stall: got %b want 0", stall_o[0]); else n_pass++;
    n_total++; if (condex_o[0] !== 1'b1) $display("FAIL fwd_condex: got %b want 1", condex_o[0]); else n_pass++;
    n_total++; if (pcsrc_o[0] !== 1'b1) $display("FAIL fwd_pcsrc: got %b want 1", pcsrc_o[0]); else n_pass++;
    n_total++; if (flags_o[0] !== 4'h8) $display("FAIL fwd_flags_before: got %h want 8", flags_o[0]); else n_pass++;
    clk_edge();
    idle_all();
    @(negedge clk);
    n_total++; if (flags_o[0] !== 4'h4) $display("FAIL fwd_flags_after: got %h want 4", flags_o[0]); else n_pass++;
    ctx_i[0] = 1;
    #1;
    n_total++; if (flags_o[0] !== 4'h0) $display("FAIL fwd_other_ctx: got %h want 0", flags_o[0]); else n_pass++;
    clk_edge();
  endtask

  task automatic test_back_to_back();
    issue(0, 0, 4'he, 2'b11);
    clk_edge();
    alu_i[0] = 4'h8; issue(0, 0, 4'h4, 2'b11);
    @(negedge clk);
    n_total++; if (stall_o[0] !== 1'b0) $display("FAIL b2b_stall1: got %b want 0", stall_o[0]); else n_pass++;
    n_total++; if (condex_o[0] !== 1'b1) $display("FAIL b2b_condex1: got %b want 1", condex_o[0]); else n_pass++;
    clk_edge();
    alu_i[0] = 4'h1; issue(0, 0, 4'h6, 2'b00);
    @(negedge clk);
    n_total++; if (condex_o[0] !== 1'b1) $display("FAIL b2b_condex2: got %b want 1", condex_o[0]); else n_pass++;
    n_total++; if (flags_o[0] !== 4'h8) $display("FAIL b2b_flags_mid: got %h want 8", flags_o[0]); else n_pass++;
    clk_edge();
    idle_all();
    @(negedge clk);
    n_total++; if (flags_o[0] !== 4'h1) $display("FAIL b2b_flags_end: got %h want 1", flags_o[0]); else n_pass++;
    clk_edge();
  endtask

  task automatic test_stall_nofwd();
    issue(1, 0, 4'he, 2'b10);
    clk_edge();
    alu_i[1] = 4'hb; issue(1, 0, 4'h1, 2'b00); pcs_i[1] = 1;
    @(negedge clk);
    n_total++; if (stall_o[1] !== 1'b1) $display("FAIL nofwd_stall1: got %b want 1", stall_o[1]); else n_pass++;
    n_total++; if (pcsrc_o[1] !== 1'b0) $display("FAIL nofwd_pcsrc1: got %b want 0", pcsrc_o[1]); else n_pass++;
    clk_edge();
    alu_i[1] = 4'h7;
    @(negedge clk);
    n_total++; if (stall_o[1] !== 1'b1) $display("FAIL nofwd_stall2: got %b want 1", stall_o[1]); else n_pass++;
    clk_edge();
    alu_i[1] = 4'h0;
    @(negedge clk);
    n_total++; if (stall_o[1] !== 1'b0) $display("FAIL nofwd_stall3: got %b want 0", stall_o[1]); else n_pass++;
    n_total++; if (condex_o[1] !== 1'b0) $display("FAIL nofwd_condex: got %b want 0", condex_o[1]); else n_pass++;
    n_total++; if (flags_o[1] !== 4'h4) $display("FAIL nofwd_flags: got %h want 4", flags_o[1]); else n_pass++;
    clk_edge();
    idle_all();
    clk_edge();
  endtask

  task automatic test_ctx_indep();
    issue(1, 0, 4'he, 2'b10);
    clk_edge();
    issue(1, 0, 4'h2, 2'b00);
    @(negedge clk);
    n_total++; if (stall_o[1] !== 1'b0) $display("FAIL ctx_cv_only_stall: got %b want 0", stall_o[1]); else n_pass++;
    n_total++; if (condex_o[1] !== 1'b0) $display("FAIL ctx_cv_only_condex: got %b want 0", condex_o[1]); else n_pass++;
    clk_edge();
    issue(1, 0, 4'he, 2'b11);
    @(negedge clk);
    n_total++; if (stall_o[1] !== 1'b0) $display("FAIL ctx_al_stall: got %b want 0", stall_o[1]); else n_pass++;
    clk_edge();
    issue(1, 1, 4'h2, 2'b00);
    @(negedge clk);
    n_total++; if (stall_o[1] !== 1'b0) $display("FAIL ctx_other_stall: got %b want 0", stall_o[1]); else n_pass++;
    ctx_i[1] = 0;
    #1;
    n_total++; if (stall_o[1] !== 1'b1) $display("FAIL ctx_same_stall: got %b want 1", stall_o[1]); else n_pass++;
    ctx_i[1] = 3;
    #1;
    n_total++; if (stall_o[1] !== 1'b1) $display("FAIL ctx_alias_stall: got %b want 1", stall_o[1]); else n_pass++;
    ctx_i[1] = 2;
    #1;
    n_total++; if (stall_o[1] !== 1'b0) $display("FAIL ctx2_stall: got %b want 0", stall_o[1]); else n_pass++;
    clk_edge();
    idle_all();
    clk_edge();
    clk_edge();
  endtask

  task automatic test_forward_lat2();
    issue(2, 1, 4'he, 2'b01);
    clk_edge();
    issue(2, 1, 4'h2, 2'b00); pcs_i[2] = 1;
    @(negedge clk);
    n_total++; if (stall_o[2] !== 1'b1) $display("FAIL fwd2_young_stall: got %b want 1", stall_o[2]); else n_pass++;
    clk_edge();
    alu_i[2] = 4'h2;
    @(negedge clk);
    n_total++; if (stall_o[2] !== 1'b0) $display("FAIL fwd2_oldest_stall: got %b want 0", stall_o[2]); else n_pass++;
    n_total++; if (pcsrc_o[2] !== 1'b1) $display("FAIL fwd2_pcsrc: got %b want 1", pcsrc_o[2]); else n_pass++;
    clk_edge();
    idle_all(); ctx_i[2] = 1;
    @(negedge clk);
    n_total++; if (flags_o[2] !== 4'h2) $display("FAIL fwd2_flags: got %h want 2", flags_o[2]); else n_pass++;
    clk_edge();
  endtask

  task automatic test_random();
    rst = 1;
    idle_all();
    clk_edge();
    clk_edge();
    rst = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int d = 0; d < 3; d++) begin
        valid_i[d] = ($urandom_range(0, 3) != 0);
        ctx_i[d]   = 2'((d == 1) ? $urandom_range(0, 3) : $urandom_range(0, 1));
        cond_i[d]  = 4'($urandom);
        flagw_i[d] = 2'($urandom);
        pcs_i[d]   = 1'($urandom);
        regw_i[d]  = 1'($urandom);
        memw_i[d]  = 1'($urandom);
        nowr_i[d]  = 1'($urandom);
        alu_i[d]   = 4'($urandom);
        flush_i[d] = ($urandom_range(0, 15) == 0);
      end
      @(negedge clk);
      model_eval();
      for (int d = 0; d < 3; d++) begin
        n_total++; if (stall_o[d] !== e_stall[d]) $display("FAIL rand_stall d=%0d cyc=%0d: got %b want %b", d, cyc, stall_o[d], e_stall[d]); else n_pass++;
        n_total++; if (condex_o[d] !== e_condex[d]) $display("FAIL rand_condex d=%0d cyc=%0d: got %b want %b", d, cyc, condex_o[d], e_condex[d]); else n_pass++;
        n_total++; if (pcsrc_o[d] !== e_pcsrc[d]) $display("FAIL rand_pcsrc d=%0d cyc=%0d: got %b want %b", d, cyc, pcsrc_o[d], e_pcsrc[d]); else n_pass++;
        n_total++; if (regw_o[d] !== e_regw[d]) $display("FAIL rand_regwrite d=%0d cyc=%0d: got %b want %b", d, cyc, regw_o[d], e_regw[d]); else n_pass++;
        n_total++; if (memw_o[d] !== e_memw[d]) $display("FAIL rand_memwrite d=%0d cyc=%0d: got %b want %b", d, cyc, memw_o[d], e_memw[d]); else n_pass++;
        n_total++; if (flags_o[d] !== e_flags[d]) $display("FAIL rand_flags d=%0d cyc=%0d: got %h want %h", d, cyc, flags_o[d], e_flags[d]); else n_pass++;
      end
      clk_edge();
    end
    rst = 0;
    idle_all();
    clk_edge();
  endtask

  initial begin
    rst = 1;
    idle_all();
    #1;
    test_reset();
    test_cond_basic();
    test_flush();
    test_no_reserve();
    test_forward();
    test_back_to_back();
    test_stall_nofwd();
    test_ctx_indep();
    test_forward_lat2();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cond_unit_pipe.md
COND_UNIT_PIPE -- requirements
Module: cond_unit_pipe

Interface
REQ-001 Parameter NCTX, default 2, SHALL set the number of independent NZCV flag contexts (1..8); CW = max(1, clog2(NCTX)).
REQ-002 Parameter FLAG_LAT, default 1, SHALL set the number of cycles from issue to ALUFlags validity (1..4).
REQ-003 Parameter FWD, default 1, SHALL enable (1) or disable (0) forwarding of in-flight ALUFlags.
REQ-004 Ports, in order:
- CLK  in  1  clock, all state on rising edge.
- RESET  in  1  synchronous, active-high reset.
- Valid  in  1  instruction presented for issue this cycle.
- Ctx  in  CW  flag context of the presented instruction.
- PCS, RegW, MemW, NoWrite  in  1 each  decoder controls.
- FlagW  in  2  bit1 = NZ group update, bit0 = CV group update.
- Cond  in  4  ARM condition field.
- ALUFlags  in  4  {N,Z,C,V} of the instruction issued FLAG_LAT cycles earlier.
- Flush  in  1  kill all in-flight flag updates.
- PCSrc, RegWrite, MemWrite  out  1 each  qualified controls.
- CondEx  out  1  condition result of the presented instruction.
- Stall  out  1  presented instruction not accepted; hold inputs.
- Flags  out  4  committed {N,Z,C,V} of context Ctx.

Function
REQ-005 Block SHALL hold NCTX committed 4-bit flag registers plus a FLAG_LAT-slot pending pipe; each slot = {valid, ctx, flagw}.
REQ-006 Cond decode SHALL be: 0000 Z, 0001 !Z, 0010 C, 0011 !C, 0100 N, 0101 !N, 0110 V, 0111 !V, 1000 C&!Z, 1001 !C|Z, 1010 N==V, 1011 N!=V, 1100 !Z&(N==V), 1101 Z|(N!=V), 1110/1111 always true.
REQ-007 Needed groups SHALL be: NZ only for 0000,0001,0100,0101; CV only for 0010,0011,0110,0111; both for 1000-1101; none for 1110,1111.
REQ-008 Effective flags SHALL be the committed flags of Ctx, overridden per group by ALUFlags when FWD=1 and the oldest slot is valid, same ctx, committing this cycle.
REQ-009 Hazard SHALL be true when Valid and some valid slot with ctx==Ctx has flagw intersecting the needed groups, excluding the oldest slot when FWD=1.
REQ-010 Stall SHALL equal hazard, combinationally, same cycle.
REQ-011 CondEx SHALL be the REQ-006 result on effective flags; PCSrc = Valid&!Stall&PCS&CondEx; RegWrite = Valid&!Stall&RegW&CondEx&!NoWrite; MemWrite = Valid&!Stall&MemW&CondEx.
REQ-012 Each edge, the pipe SHALL shift one slot toward the oldest; the new youngest slot = {Valid&!Stall&CondEx&(FlagW!=0), Ctx, FlagW}, else a bubble.
REQ-013 On each edge where the oldest slot is valid and Flush=0, its ctx flags SHALL take ALUFlags[3:2] if flagw[1] and ALUFlags[1:0] if flagw[0].
REQ-014 Flush=1 SHALL invalidate all slots, including the oldest, with no commit; the presented instruction SHALL still evaluate, and is pushed if accepted.
REQ-015 Instructions whose condition fails SHALL NOT reserve a slot or modify flags.
REQ-016 Contexts SHALL be fully independent; a pending write in context a SHALL never stall context b.
REQ-017 Ctx >= NCTX SHALL be treated as context 0.

Reset
REQ-018 RESET=1 at an edge SHALL clear all context flags to 0000 and all slot valids to 0.
REQ-019 While RESET=1, PCSrc, RegWrite, MemWrite, CondEx and Stall SHALL be 0; Flags SHALL show 0000 after the first reset edge.
REQ-020 RESET SHALL take priority over Flush and commit in the same cycle.

Verification
REQ-021 Reset, then Valid, Cond=0000, PCS=1, ctx 0 -> CondEx=0, PCSrc=0; Cond=1110 -> PCSrc=1.
REQ-022 FLAG_LAT=1, FWD=1: issue FlagW=11; next cycle ALUFlags=0100 with a dependent Cond=0000 -> Stall=0, CondEx=1; Flags = 0100 one cycle later.
REQ-023 FLAG_LAT=2, FWD=0: FlagW=10 then Cond=0001 -> Stall=1 for 2 cycles, then accept with committed Z.
REQ-024 FLAG_LAT=2: issue FlagW=10, ctx 0, then Cond=0010 (CV only), ctx 0 -> Stall=0; same cond in ctx 1 after FlagW=11 in ctx 0 -> Stall=0.
REQ-025 Pending FlagW=11 with Flush=1 on the commit cycle, ALUFlags=1111 -> Flags unchanged (0000).
REQ-026 Failed-condition instruction with FlagW=11, then a dependent Cond=0000 -> no stall, flags unchanged.
